// File: rtl/tick_scheduler_pkg.sv
// yabot_tick_pkg: shared constants and the channel-config record for tick_scheduler
package yabot_tick_pkg;
  localparam int PW_DEFAULT = 16;
  localparam int NCH_MAX = 16;
  localparam int PW_MAX = 32;
  typedef struct packed {
    logic [PW_MAX-1:0] period;
    logic en;
    logic oneshot;
  } ch_cfg_t;
endpackage

// File: rtl/tick_scheduler_channel.sv
// tick_channel: one tick channel (count, period, enable, tick register); one-shot mode under TICK_SCHEDULER_ONESHOT_EN
module tick_channel
  import yabot_tick_pkg::*;
#(
  parameter int PW = PW_DEFAULT
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    pre_tick,
  input  logic    apply,
  input  ch_cfg_t cfg,
  output logic    tick,
  output logic    active
);
  logic [PW-1:0] cnt, per;
  logic os, expire, unused_cfg;
  assign unused_cfg = ^cfg;
  assign expire = pre_tick && active && cnt == per - PW'(1);
`ifdef TICK_SCHEDULER_ONESHOT_EN
  // one-shot flag captured from the applied config
  always_ff @(posedge clk) os <= reset ? 1'b0 : apply ? cfg.oneshot : os;
`else
  assign os = 1'b0;
`endif
  // apply reloads and suppresses a coinciding tick; otherwise count strobes and tick on expiry
  always_ff @(posedge clk)
    if (reset) begin
      cnt <= '0;
      per <= '0;
      active <= 1'b0;
      tick <= 1'b0;
    end else if (apply) begin
      per <= cfg.period[PW-1:0];
      active <= cfg.en && cfg.period[PW-1:0] != '0;
      cnt <= '0;
      tick <= 1'b0;
    end else begin
      tick <= expire;
      if (pre_tick && active) cnt <= expire ? '0 : cnt + 1'b1;
      if (expire && os) active <= 1'b0;
    end
endmodule

// File: rtl/tick_scheduler.sv
// tick_scheduler: shared prescaler, single-slot config write, NCH tick channels; TICK_SCHEDULER_ONESHOT_EN enables one-shot channels
module tick_scheduler
  import yabot_tick_pkg::*;
#(
  parameter int NCH = 4,
  parameter int PRE = 8,
  parameter int PW = PW_DEFAULT,
  localparam int CHW = NCH > 1 ? $clog2(NCH) : 1,
  localparam int CW = PRE > 1 ? $clog2(PRE) : 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           cfg_valid,
  output logic           cfg_ready,
  input  logic [CHW-1:0] cfg_ch,
  input  logic [PW-1:0]  cfg_period,
  input  logic           cfg_en,
  input  logic           cfg_oneshot,
  output logic           pre_tick,
  output logic [NCH-1:0] tick,
  output logic [NCH-1:0] active
);
  logic [CW-1:0] pcnt;
  logic pend_v, os_in;
  logic [CHW-1:0] pend_ch;
  ch_cfg_t pend;
`ifdef TICK_SCHEDULER_ONESHOT_EN
  assign os_in = cfg_oneshot;
`else
  logic unused_oneshot;
  assign unused_oneshot = cfg_oneshot;
  assign os_in = 1'b0;
`endif
  assign pre_tick = PRE <= 1 ? 1'b1 : pcnt == CW'(PRE - 1);
  assign cfg_ready = !reset && !pend_v;
  // prescaler wraps after the strobe cycle
  always_ff @(posedge clk) pcnt <= reset || pre_tick ? '0 : pcnt + 1'b1;
  // pending slot: filled on handshake, freed on the strobe that applies it
  always_ff @(posedge clk)
    if (reset) begin
      pend_v <= 1'b0;
      pend_ch <= '0;
      pend <= '0;
    end else if (pend_v && pre_tick) begin
      pend_v <= 1'b0;
    end else if (cfg_valid && cfg_ready) begin
      pend_v <= 1'b1;
      pend_ch <= cfg_ch;
      pend <= '{period: PW_MAX'(cfg_period), en: cfg_en, oneshot: os_in};
    end
  for (genvar g = 0; g < NCH; g++) begin : g_ch
    tick_channel #(.PW(PW)) u_ch (
      .clk(clk),
      .reset(reset),
      .pre_tick(pre_tick),
      .apply(pend_v && pre_tick && pend_ch == CHW'(g)),
      .cfg(pend),
      .tick(tick[g]),
      .active(active[g])
    );
  end
endmodule

// File: tb/tb_tick_scheduler.sv
// tb_tick_scheduler: randomized and directed stimulus against a strobe-counting reference model
module tb_tick_scheduler;
  localparam int NCH = 4, PRE = 4, PW = 16, CHW = 2;
  logic clk = 1'b0, reset, cfg_valid, cfg_ready, cfg_en, cfg_oneshot, pre_tick;
  logic [CHW-1:0] cfg_ch;
  logic [PW-1:0] cfg_period;
  logic [NCH-1:0] tick, active;
  int n_cmp = 0, n_err = 0;
  int k, m_pch, m_pper;
  bit m_pend, m_pen, m_pos;
  int m_per[NCH], m_n[NCH];
  bit m_en[NCH], m_os[NCH];
  bit [NCH-1:0] m_tick;

  always #5 clk = ~clk;

  tick_scheduler #(.NCH(NCH), .PRE(PRE), .PW(PW)) dut (
    .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch), .cfg_period(cfg_period), .cfg_en(cfg_en), .cfg_oneshot(cfg_oneshot),
    .pre_tick(pre_tick), .tick(tick), .active(active)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit m_pre();
    return PRE <= 1 || (k % PRE == PRE - 1);
  endfunction

  task automatic model_edge();
    bit p;
    bit [NCH-1:0] nt;
    if (reset) begin
      k = 0;
      m_pend = 0;
      m_tick = '0;
      for (int i = 0; i < NCH; i++) begin
        m_per[i] = 0; m_n[i] = 0; m_en[i] = 0; m_os[i] = 0;
      end
      return;
    end
    p = m_pre();
    nt = '0;
    for (int i = 0; i < NCH; i++)
      if (p && m_en[i]) begin
        m_n[i]++;
        if (m_n[i] % m_per[i] == 0) begin
          nt[i] = 1;
          if (m_os[i]) m_en[i] = 0;
        end
      end
    if (p && m_pend) begin
      if (m_pch < NCH) begin
        m_per[m_pch] = m_pper;
        m_en[m_pch] = m_pen && m_pper != 0;
        m_os[m_pch] = m_pos;
        m_n[m_pch] = 0;
        nt[m_pch] = 0;
      end
      m_pend = 0;
    end else if (cfg_valid && !m_pend) begin
      m_pend = 1;
      m_pch = int'(cfg_ch);
      m_pper = int'(cfg_period);
      m_pen = cfg_en;
`ifdef TICK_SCHEDULER_ONESHOT_EN
      m_pos = cfg_oneshot;
`else
      m_pos = 0;
`endif
    end
    m_tick = nt;
    k++;
  endtask

  task automatic check_outputs();
    bit [NCH-1:0] ae;
    for (int i = 0; i < NCH; i++) ae[i] = m_en[i];
    chk("pre_tick", pre_tick, m_pre());
    chk("cfg_ready", cfg_ready, !reset && !m_pend);
    chk("tick", tick, m_tick);
    chk("active", active, ae);
  endtask

  task automatic step(input bit v, input int ch, input int per, input bit en, input bit os, input bit rst);
    cfg_valid = v;
    cfg_ch = CHW'(ch);
    cfg_period = PW'(per);
    cfg_en = en;
    cfg_oneshot = os;
    reset = rst;
    model_edge();
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic write(input int ch, input int per, input bit en, input bit os);
    for (int t = 0; t < 20; t++) begin
      bit acc;
      acc = cfg_ready;
      step(1, ch, per, en, os, 0);
      if (acc) begin
        cfg_valid = 0;
        return;
      end
    end
    chk("write_timeout", 0, 1);
  endtask

  initial begin
    int t0, t1, pl[6];
    pl = '{0, 1, 2, 3, 5, 7};
    reset = 1; cfg_valid = 0; cfg_ch = '0; cfg_period = '0; cfg_en = 0; cfg_oneshot = 0;
    @(negedge clk);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    chk("rst_tick", tick, 0);
    chk("rst_active", active, 0);
    idle(3);
    write(0, 3, 1, 0);
    t0 = -1; t1 = -1;
    for (int i = 0; i < 40; i++) begin
      step(0, 0, 0, 0, 0, 0);
      if (tick[0]) begin
        if (t0 < 0) t0 = i;
        else if (t1 < 0) t1 = i;
      end
    end
    chk("ch0_interval", t1 - t0, 12);
    write(1, 5, 1, 0);
    write(2, 2, 1, 0);
    idle(30);
    write(1, 2, 1, 0);
    idle(20);
    write(2, 2, 1, 1);
    idle(30);
    step(1, 3, 7, 1, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    chk("mid_rst_tick", tick, 0);
    chk("mid_rst_active", active, 0);
    idle(40);
    chk("post_rst_active", active, 0);
    write(3, 0, 1, 0);
    idle(20);
    chk("ch3_zero_period", active[3], 0);
    for (int i = 0; i < 3000; i++) begin
      int per;
      per = $urandom_range(0, 6) == 6 ? int'($urandom_range(1, 20)) : pl[$urandom_range(0, 5)];
      step($urandom_range(0, 3) == 0, $urandom_range(0, NCH - 1), per,
           $urandom_range(0, 7) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 299) == 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
